// File: rtl/cache_pkg.sv
// Shared cache definitions: fill-controller state encoding and block geometry
// used by the miss-handling FSM, the cache arrays and the tag compare.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Default geometry: 8 words of 16 bits per block.
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES         = DEF_WORDS_PER_BLOCK * 2;
  localparam int WORD_SEL_W          = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int OFFSET_BITS         = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous reset, synchronous clear and count enable.
// Clear has priority over enable; the count wraps at 2^WIDTH.
module fill_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Count register: reset and clear return to zero, enable advances by one.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, regardless of block order.
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller. On a miss it issues one word read per cycle for
// the whole block, steers each returned word into the data array in arrival
// order and writes the tag with the last word. Returned words are counted,
// never timed, so any fixed memory latency works.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int AWIDTH          = 16,
  parameter int DWIDTH          = 16,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [AWIDTH-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [DWIDTH-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               mem_enable,
  output logic [AWIDTH-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_sel,
  output logic [DWIDTH-1:0]                  cache_data,
  output logic                               write_tag_array,
  output logic                               fill_done
);

  localparam int SEL_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = SEL_W + 1;

  // Byte-offset bits inside a block; cleared to form the block base address.
  localparam logic [AWIDTH-1:0] OFFSET_MASK = AWIDTH'(WORDS_PER_BLOCK * 2 - 1);

  fill_state_t       state;
  fill_state_t       state_next;
  logic [AWIDTH-1:0] block_base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [SEL_W-1:0]  recv_cnt;

  logic start;
  logic issuing;
  logic receiving;
  logic recv_last;

  // A miss is only accepted while idle; misses during a fill are ignored.
  assign start     = (state == IDLE) && miss_detected;
  assign issuing   = (state == FILL) && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
  assign receiving = (state == FILL) && memory_data_valid;
  assign recv_last = (recv_cnt == SEL_W'(WORDS_PER_BLOCK - 1));

  fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (issuing),
    .count  (issue_cnt)
  );

  fill_counter #(.WIDTH(SEL_W)) u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .enable (receiving),
    .count  (recv_cnt)
  );

  // State register; reset aborts any fill in progress without a tag write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the block-aligned base address when a fill starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_base <= '0;
    end else if (start) begin
      block_base <= miss_address & ~OFFSET_MASK;
    end
  end

  // Next state plus outputs: Moore request side, Mealy response side.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_next       = state;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    cache_word_sel   = '0;
    cache_data       = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_next = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issuing) begin
          mem_enable     = 1'b1;
          memory_address = block_base + (AWIDTH'(issue_cnt) << 1);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          cache_word_sel   = recv_cnt;
          cache_data       = memory_data;
          if (recv_last) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            state_next      = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a fixed-latency pipelined memory
// model answers read requests, and a transaction-level reference model of the
// fill (busy flag, base, words issued, words received) predicts every output
// each cycle. Directed scenarios are followed by randomized fills.
module tb_cache_fill_fsm;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  cache_word_sel;
  logic [15:0] cache_data;
  logic        write_tag_array;
  logic        fill_done;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .cache_word_sel    (cache_word_sel),
    .cache_data        (cache_data),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Memory model: scheduled returns keyed by the cycle they come back.
  bit          ret_v[int];
  logic [15:0] ret_d[int];
  int          mem_lat = 4;

  // Per-cycle stimulus requested by the scenario code.
  logic        d_rst        = 1'b0;
  logic        d_miss       = 1'b0;
  logic [15:0] d_addr       = '0;
  logic        d_stray      = 1'b0;
  logic [15:0] d_stray_data = '0;

  // Reference model of one fill transaction.
  bit          m_busy   = 1'b0;
  logic [15:0] m_base   = '0;
  int          m_issued = 0;
  int          m_recv   = 0;

  // Observations for scenario-level checks.
  int          obs_busy  = 0;
  int          obs_tag   = 0;
  int          tag_cyc   = 0;
  int          start_cyc = 0;
  logic [15:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic step();
    logic        e_men;
    logic        e_wr;
    logic        e_tag;
    logic [15:0] e_addr;
    @(posedge clk);
    #1;
    cyc++;
    rst           = d_rst;
    miss_detected = d_miss;
    miss_address  = d_addr;
    if (ret_v.exists(cyc)) begin
      memory_data_valid = 1'b1;
      memory_data       = ret_d[cyc];
      ret_v.delete(cyc);
      ret_d.delete(cyc);
    end else if (d_stray) begin
      memory_data_valid = 1'b1;
      memory_data       = d_stray_data;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
    #3;
    e_men  = m_busy && (m_issued < W);
    e_addr = e_men ? m_base + 16'(2 * m_issued) : 16'h0000;
    e_wr   = m_busy && memory_data_valid;
    e_tag  = e_wr && (m_recv == W - 1);
    check("fsm_busy", fsm_busy, m_busy);
    check("mem_enable", mem_enable, e_men);
    check("memory_address", memory_address, e_addr);
    check("write_data_array", write_data_array, e_wr);
    check("write_tag_array", write_tag_array, e_tag);
    check("fill_done", fill_done, e_tag);
    if (e_wr) begin
      check("cache_word_sel", cache_word_sel, m_recv);
      check("cache_data", cache_data, memory_data);
    end
    obs_busy += int'(fsm_busy);
    if (write_tag_array) begin
      obs_tag++;
      tag_cyc = cyc;
    end
    if (mem_enable) last_addr = memory_address;
    if (e_men) begin
      ret_v[cyc + mem_lat] = 1'b1;
      ret_d[cyc + mem_lat] = 16'($urandom);
    end
    // Advance the reference model at the coming edge.
    if (rst) begin
      m_busy   = 1'b0;
      m_base   = '0;
      m_issued = 0;
      m_recv   = 0;
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_busy   = 1'b1;
        m_base   = miss_address & 16'hFFF0;
        m_issued = 0;
        m_recv   = 0;
      end
    end else begin
      if (m_issued < W) m_issued++;
      if (memory_data_valid) begin
        if (m_recv == W - 1) m_busy = 1'b0;
        else m_recv++;
      end
    end
  endtask

  task automatic clear_obs();
    obs_busy  = 0;
    obs_tag   = 0;
    start_cyc = cyc + 1;
  endtask

  // Step until both model and DUT are idle, with a bounded cycle budget.
  task automatic wait_idle();
    int n = 0;
    do begin
      step();
      n++;
    end while ((m_busy || fsm_busy) && n < 200);
    check("drain_busy", fsm_busy, 1'b0);
  endtask

  // Present a single-cycle miss and run the fill to completion.
  task automatic fill(input logic [15:0] a);
    clear_obs();
    d_miss = 1'b1;
    d_addr = a;
    step();
    d_miss = 1'b0;
    wait_idle();
  endtask

  task automatic idle(input int n);
    d_miss  = 1'b0;
    d_rst   = 1'b0;
    d_stray = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int n;
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    repeat (2) @(posedge clk);

    // Reset state observed in the first released cycle.
    idle(2);

    // Latency 4, miss at 0x1236: busy 12 cycles, tag on cycle 12.
    mem_lat = 4;
    fill(16'h1236);
    check("t1_busy_len", obs_busy, 12);
    check("t1_tag_count", obs_tag, 1);
    check("t1_tag_cycle", tag_cyc - start_cyc, 12);
    check("t1_last_addr", last_addr, 16'h123E);

    // Reset on cycle 6 of a fill aborts it without a tag write.
    clear_obs();
    d_miss = 1'b1;
    d_addr = 16'h3456;
    step();
    d_miss = 1'b0;
    repeat (5) step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check("t2_busy_after_rst", fsm_busy, 1'b0);
    check("t2_men_after_rst", mem_enable, 1'b0);
    check("t2_addr_after_rst", memory_address, 16'h0000);
    idle(8);
    check("t2_no_tag", obs_tag, 0);
    fill(16'h0040);
    check("t2_refill_busy", obs_busy, 12);
    check("t2_refill_tags", obs_tag, 1);
    check("t2_refill_last", last_addr, 16'h004E);

    // Second miss held through a fill starts right after the first completes.
    clear_obs();
    d_miss = 1'b1;
    d_addr = 16'h1000;
    step();
    d_addr = 16'h2000;
    n = 0;
    do begin
      step();
      n++;
    end while (!write_tag_array && n < 100);
    check("t3_tag_seen", write_tag_array, 1'b1);
    step();
    check("t3_gap_busy", fsm_busy, 1'b0);
    step();
    check("t3_next_men", mem_enable, 1'b1);
    check("t3_next_addr", memory_address, 16'h2000);
    d_miss = 1'b0;
    wait_idle();
    check("t3_tags", obs_tag, 2);

    // Stray return data while idle is ignored.
    idle(2);
    d_stray      = 1'b1;
    d_stray_data = 16'hBEEF;
    step();
    check("t4_no_write", write_data_array, 1'b0);
    d_stray = 1'b0;
    step();
    check("t4_still_idle", fsm_busy, 1'b0);

    // Top-of-memory block with latency 1: no wrap, busy 9 cycles.
    mem_lat = 1;
    fill(16'hFFFA);
    check("t5_busy_len", obs_busy, 9);
    check("t5_tag_count", obs_tag, 1);
    check("t5_last_addr", last_addr, 16'hFFFE);

    // Randomized fills: varying latency, stray data, ignored and back-to-back
    // misses, occasional resets.
    for (int it = 0; it < 40; it++) begin
      if (ret_v.num() == 0) mem_lat = $urandom_range(1, 6);
      repeat ($urandom_range(0, 3)) begin
        d_stray      = ($urandom_range(0, 3) == 0);
        d_stray_data = 16'($urandom);
        step();
      end
      d_stray = 1'b0;
      d_miss  = 1'b1;
      d_addr  = 16'($urandom);
      step();
      n = 0;
      do begin
        d_miss = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom);
        d_rst  = ($urandom_range(0, 63) == 0);
        step();
        n++;
      end while ((m_busy || fsm_busy) && n < 200);
      d_rst  = 1'b0;
      d_miss = 1'b0;
      check("rand_drain", fsm_busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's I-/D-cache arrays and the multi-cycle main memory (memory4c-style, pipelined, fixed but unspecified read latency).
- On a cache miss it fetches the whole 16-byte block, issuing one word read per cycle.
- It steers each returned word into the data array, then writes the tag.
- It holds the pipeline stalled via `fsm_busy` until the block is resident; one instance sits downstream of each cache.

Parameters:
- `AWIDTH`, 16, byte-address width.
- `DWIDTH`, 16, memory word width.
- `WORDS_PER_BLOCK`, 8, words per cache block; power of two; block bytes = `WORDS_PER_BLOCK*2`.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `miss_detected`  in  1  cache lookup missed this cycle
- `miss_address`  in  AWIDTH  byte address of the missing access
- `memory_data_valid`  in  1  main memory returns a read word this cycle
- `memory_data`  in  DWIDTH  returned read data
- `fsm_busy`  out  1  fill in progress; stall requester
- `mem_enable`  out  1  read request to main memory this cycle
- `memory_address`  out  AWIDTH  read address issued to main memory
- `write_data_array`  out  1  write `memory_data` into the data array
- `cache_word_sel`  out  log2(WORDS_PER_BLOCK)  word offset within block for that write
- `cache_data`  out  DWIDTH  data to the data array (pass-through of `memory_data`)
- `write_tag_array`  out  1  write tag/valid for `block_base`; one-cycle pulse
- `fill_done`  out  1  one-cycle pulse, same cycle as `write_tag_array`

Behaviour:
- Internal regs:
  - `state` {IDLE, FILL}
  - `block_base` (AWIDTH)
  - `issue_cnt` (log2 W + 1 bits)
  - `recv_cnt` (log2 W bits)
- Reset (sync, `rst`=1 at edge):
  - state=IDLE, all counters=0, `block_base`=0.
  - All outputs 0 in the following cycle.
  - Overrides everything, including mid-fill; an aborted fill never writes the tag.
- IDLE:
  - `fsm_busy`=0, `mem_enable`=0.
  - If `miss_detected`=1: `block_base` <= `miss_address` with low log2(W*2) bits cleared; counters <= 0; state <= FILL.
- FILL, request side (Moore):
  - `fsm_busy`=1.
  - While `issue_cnt`<W: `mem_enable`=1, `memory_address`=`block_base`+2*`issue_cnt`; `issue_cnt` increments each cycle.
  - After W issues: `mem_enable`=0 and `memory_address`=0 while waiting for data.
- FILL, response side (Mealy, same cycle as `memory_data_valid`):
  - `write_data_array`=1, `cache_word_sel`=`recv_cnt`, `cache_data`=`memory_data`; `recv_cnt` increments.
- Completion:
  - Valid with `recv_cnt`=W-1 → `write_tag_array`=1 and `fill_done`=1 that cycle.
  - state <= IDLE; `fsm_busy`=0 the next cycle.
- Latency: no latency value is built in; returned words are counted, never timed. With memory latency L, busy lasts W+L cycles.
- Words may return before all W requests have issued; this is legal and handled in order.
- `memory_data_valid` in IDLE is ignored: no array write.
- `miss_detected` while FILL is ignored; the requester re-presents the miss after busy drops.
- `miss_detected` in the same cycle busy falls (IDLE) starts a new fill immediately, giving back-to-back fills.
- Address arithmetic wraps modulo 2^AWIDTH. A block at 0xFFF0 issues 0xFFF0..0xFFFE with no carry out.
- No outputs are X in any state.

Decomposition:
- Shared package `cache_pkg`:
  - state enum {IDLE, FILL}
  - `BLOCK_BYTES`, `WORD_SEL_W`, `OFFSET_BITS` localparams, also used by the cache arrays and tag compare.
- Sub-module `fill_counter`: a parameterized up-counter with sync clear and enable. Instantiate it twice, for the issue and receive counts.

Test Plan:
- Memory model latency 4. Miss at 0x1236 at cycle 0 → `memory_address` 0x1230,0x1232..0x123E on cycles 1–8 with `mem_enable`=1; `write_data_array` cycles 5–12 with `cache_word_sel` 0..7; `write_tag_array`/`fill_done` cycle 12; `fsm_busy` 1 on cycles 1–12, 0 on cycle 13.
- `rst` asserted at cycle 6 of a fill → cycle 7 all outputs 0, state IDLE; no `write_tag_array`. A new miss at 0x0040 then fills 0x0040..0x004E cleanly with `cache_word_sel` starting at 0.
- Second miss (0x2000) held high throughout a fill of 0x1000 → only 0x1000-block addresses issue; the 0x2000 fill starts the cycle after `fill_done`.
- Stray `memory_data_valid`=1 with data 0xBEEF in IDLE → `write_data_array`=0, no state change.
- Miss at 0xFFFA → addresses 0xFFF0..0xFFFE, no wrap to 0x0000; memory latency 1 → busy 9 cycles, tag pulse exactly once.
